// File: rtl/activation_pingpong_buffer_if.sv
//------------------------------------------------------------------------------
// Module      : activation_pingpong_buffer_if
// Description : Write/read handshake bundle for the activation ping-pong buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface activation_pingpong_buffer_if #(
  parameter int DATA_WIDTH        = 7,
  parameter int LANES             = 4,
  parameter int BUFFER_ADDR_WIDTH = 15
);
  logic                          wr_en_i;
  logic [BUFFER_ADDR_WIDTH-1:0]  wr_addr_i;
  logic [LANES-1:0]              wr_lane_mask_i;
  logic [DATA_WIDTH*LANES-1:0]   wr_data_i;
  logic                          wr_commit_i;
  logic                          wr_ready_o;
  logic                          wr_bank_o;
  logic                          rd_en_i;
  logic [BUFFER_ADDR_WIDTH-1:0]  rd_addr_i;
  logic                          rd_pad_i;
  logic                          rd_release_i;
  logic                          rd_ready_o;
  logic                          rd_bank_o;
  logic                          rd_valid_o;
  logic [BUFFER_ADDR_WIDTH-1:0]  rd_addr_o;
  logic [DATA_WIDTH*LANES-1:0]   rd_data_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_lane_mask_i, wr_data_i, wr_commit_i,
    output rd_en_i, rd_addr_i, rd_pad_i, rd_release_i,
    input  wr_ready_o, wr_bank_o, rd_ready_o, rd_bank_o,
    input  rd_valid_o, rd_addr_o, rd_data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_lane_mask_i, wr_data_i, wr_commit_i,
    input  rd_en_i, rd_addr_i, rd_pad_i, rd_release_i,
    output wr_ready_o, wr_bank_o, rd_ready_o, rd_bank_o,
    output rd_valid_o, rd_addr_o, rd_data_o
  );
endinterface

`default_nettype wire

// File: rtl/activation_pingpong_buffer.sv
//------------------------------------------------------------------------------
// Module      : activation_pingpong_buffer
// Description : Two-bank ping-pong activation store, lane-masked writes,
//               2-cycle pipelined reads with zero-pad option.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module activation_pingpong_buffer #(
  parameter int DATA_WIDTH        = 7,
  parameter int LANES             = 4,
  parameter int BUFFER_ADDR_WIDTH = 15
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  activation_pingpong_buffer_if.slave     bus
);

  localparam int c_WORD_W = DATA_WIDTH * LANES;
  localparam int c_PTR_W  = BUFFER_ADDR_WIDTH + 1;
  localparam int c_DEPTH  = 2 ** c_PTR_W;

  logic [1:0]                   r_full;
  logic [1:0]                   w_full_nxt;
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic                         w_wr_ready;
  logic                         w_rd_ready;
  logic                         w_wr_fire;
  logic                         w_rd_fire;
  logic                         w_commit;
  logic                         w_release;
  logic [c_PTR_W-1:0]           w_wr_ptr;
  logic [c_PTR_W-1:0]           w_rd_ptr;

  logic                         r_s1_valid;
  logic                         r_s1_pad;
  logic [BUFFER_ADDR_WIDTH-1:0] r_s1_addr;
  logic [c_WORD_W-1:0]          w_s1_data;

  logic                         r_rd_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] r_rd_addr;
  logic [c_WORD_W-1:0]          r_rd_data;

  assign w_wr_ready = ~r_full[r_wr_bank];
  assign w_rd_ready =  r_full[r_rd_bank];
  assign w_wr_fire  = bus.wr_en_i     & w_wr_ready;
  assign w_commit   = bus.wr_commit_i & w_wr_ready;
  assign w_rd_fire  = bus.rd_en_i     & w_rd_ready;
  assign w_release  = bus.rd_release_i & w_rd_ready;
  assign w_wr_ptr   = {r_wr_bank, bus.wr_addr_i};
  assign w_rd_ptr   = {r_rd_bank, bus.rd_addr_i};

  // Commit needs an empty write bank and release a full read bank, so the two
  // never target the same bank in one cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit)  w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_commit)  r_wr_bank <= ~r_wr_bank;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  // One RAM per lane so each lane's write enable is independent.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_lane;

    always_ff @(posedge clk) begin
      if (w_wr_fire && bus.wr_lane_mask_i[k])
        r_mem[w_wr_ptr] <= bus.wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      if (w_rd_fire)
        r_rd_lane <= r_mem[w_rd_ptr];
    end

    assign w_s1_data[k*DATA_WIDTH +: DATA_WIDTH] = r_rd_lane;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pad   <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_s1_pad  <= bus.rd_pad_i;
        r_s1_addr <= bus.rd_addr_i;
      end
    end
  end

  // Output register holds its last word while no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rd_addr <= r_s1_addr;
        r_rd_data <= r_s1_pad ? '0 : w_s1_data;
      end
    end
  end

  assign bus.wr_ready_o = w_wr_ready;
  assign bus.wr_bank_o  = r_wr_bank;
  assign bus.rd_ready_o = w_rd_ready;
  assign bus.rd_bank_o  = r_rd_bank;
  assign bus.rd_valid_o = r_rd_valid;
  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.rd_data_o  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_activation_pingpong_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_activation_pingpong_buffer
// Description : Directed self-checking bench for activation_pingpong_buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_activation_pingpong_buffer;

  localparam int c_DW = 7;
  localparam int c_LN = 4;
  localparam int c_AW = 15;
  localparam int c_W  = c_DW * c_LN;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [c_W-1:0] d [4];

  activation_pingpong_buffer_if #(
    .DATA_WIDTH(c_DW), .LANES(c_LN), .BUFFER_ADDR_WIDTH(c_AW)
  ) bus ();

  activation_pingpong_buffer #(
    .DATA_WIDTH(c_DW), .LANES(c_LN), .BUFFER_ADDR_WIDTH(c_AW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [c_W-1:0] pack4(input int l0, l1, l2, l3);
    return {c_DW'(l3), c_DW'(l2), c_DW'(l1), c_DW'(l0)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_write(input int addr, input logic [3:0] mask,
                          input logic [c_W-1:0] data, input logic commit);
    bus.wr_en_i        = 1'b1;
    bus.wr_addr_i      = c_AW'(addr);
    bus.wr_lane_mask_i = mask;
    bus.wr_data_i      = data;
    bus.wr_commit_i    = commit;
    step();
    bus.wr_en_i        = 1'b0;
    bus.wr_commit_i    = 1'b0;
  endtask

  task automatic do_commit();
    bus.wr_commit_i = 1'b1;
    step();
    bus.wr_commit_i = 1'b0;
  endtask

  task automatic do_release();
    bus.rd_release_i = 1'b1;
    step();
    bus.rd_release_i = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic pad,
                            input logic [c_W-1:0] exp);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = c_AW'(addr);
    bus.rd_pad_i  = pad;
    step();
    bus.rd_en_i   = 1'b0;
    bus.rd_pad_i  = 1'b0;
    check({tag, "_early"}, 64'(bus.rd_valid_o), 64'd0);
    step();
    check({tag, "_valid"}, 64'(bus.rd_valid_o), 64'd1);
    check({tag, "_addr"},  64'(bus.rd_addr_o),  64'(addr));
    check({tag, "_data"},  64'(bus.rd_data_o),  64'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4; i++) d[i] = 28'h0ABCDEF + 28'(i) * 28'h0101010;
    rst = 1'b1;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_lane_mask_i = '0;
    bus.wr_data_i = '0; bus.wr_commit_i = 1'b0;
    bus.rd_en_i = 1'b0; bus.rd_addr_i = '0; bus.rd_pad_i = 1'b0;
    bus.rd_release_i = 1'b0;
    step(); step();
    check("rst_wr_ready", 64'(bus.wr_ready_o), 64'd1);
    check("rst_rd_ready", 64'(bus.rd_ready_o), 64'd0);
    check("rst_wr_bank",  64'(bus.wr_bank_o),  64'd0);
    check("rst_rd_bank",  64'(bus.rd_bank_o),  64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("rst_rd_data",  64'(bus.rd_data_o),  64'd0);
    rst = 1'b0;
    step();

    // Fill bank0 and commit
    for (int i = 0; i < 4; i++) do_write(i, 4'b1111, d[i], 1'b0);
    do_commit();
    check("c0_wr_bank",  64'(bus.wr_bank_o),  64'd1);
    check("c0_rd_bank",  64'(bus.rd_bank_o),  64'd0);
    check("c0_rd_ready", 64'(bus.rd_ready_o), 64'd1);
    check("c0_wr_ready", 64'(bus.wr_ready_o), 64'd1);

    // Back-to-back reads of bank0 while bank1 takes a write
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        check("pipe_valid", 64'(bus.rd_valid_o), 64'd1);
        check("pipe_addr",  64'(bus.rd_addr_o),  64'(c - 2));
        check("pipe_data",  64'(bus.rd_data_o),  64'(d[c-2]));
      end
      bus.rd_en_i        = (c < 4);
      bus.rd_addr_i      = c_AW'(c);
      bus.wr_en_i        = (c == 0);
      bus.wr_addr_i      = c_AW'(5);
      bus.wr_lane_mask_i = 4'b1111;
      bus.wr_data_i      = pack4(1, 2, 3, 4);
      step();
    end
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    check("hold_valid", 64'(bus.rd_valid_o), 64'd0);
    check("hold_addr",  64'(bus.rd_addr_o),  64'd3);
    check("hold_data",  64'(bus.rd_data_o),  64'(d[3]));

    // Partial-lane overwrite in bank1, then fill both banks
    do_write(5, 4'b0101, pack4(9, 9, 9, 9), 1'b0);
    do_commit();
    check("full_wr_ready", 64'(bus.wr_ready_o), 64'd0);
    check("full_wr_bank",  64'(bus.wr_bank_o),  64'd0);
    do_write(0, 4'b1111, 28'h5555555, 1'b1);
    check("ign_wr_ready", 64'(bus.wr_ready_o), 64'd0);
    check("ign_wr_bank",  64'(bus.wr_bank_o),  64'd0);
    do_release();
    check("rel_wr_ready", 64'(bus.wr_ready_o), 64'd1);
    check("rel_wr_bank",  64'(bus.wr_bank_o),  64'd0);
    check("rel_rd_bank",  64'(bus.rd_bank_o),  64'd1);
    check("rel_rd_ready", 64'(bus.rd_ready_o), 64'd1);

    read_check("mask", 5, 1'b0, pack4(9, 2, 9, 4));
    read_check("pad",  7, 1'b1, '0);

    // Release bank1: nothing readable, so reads are dropped
    do_release();
    check("empty_rd_ready", 64'(bus.rd_ready_o), 64'd0);
    check("empty_rd_bank",  64'(bus.rd_bank_o),  64'd0);
    bus.rd_en_i = 1'b1;
    bus.rd_addr_i = c_AW'(1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("nordy_valid", 64'(bus.rd_valid_o), 64'd0);
    end
    bus.rd_en_i = 1'b0;
    check("nordy_addr_hold", 64'(bus.rd_addr_o), 64'd7);

    // Write together with commit lands in the committed bank
    do_write(2, 4'b1111, 28'h1234567, 1'b1);
    check("wc_wr_bank",  64'(bus.wr_bank_o),  64'd1);
    check("wc_rd_ready", 64'(bus.rd_ready_o), 64'd1);
    read_check("keep0", 0, 1'b0, d[0]);
    read_check("wc2",   2, 1'b0, 28'h1234567);

    // Reset with reads in flight
    bus.rd_en_i = 1'b1;
    bus.rd_addr_i = c_AW'(0);
    step();
    bus.rd_addr_i = c_AW'(1);
    #1 rst = 1'b1;
    step();
    bus.rd_en_i = 1'b0;
    check("rstf_valid0", 64'(bus.rd_valid_o), 64'd0);
    step();
    rst = 1'b0;
    check("rstf_valid1", 64'(bus.rd_valid_o), 64'd0);
    step();
    check("rstf_valid2", 64'(bus.rd_valid_o), 64'd0);
    check("rstf_wr_ready", 64'(bus.wr_ready_o), 64'd1);
    check("rstf_rd_ready", 64'(bus.rd_ready_o), 64'd0);
    check("rstf_wr_bank",  64'(bus.wr_bank_o),  64'd0);
    check("rstf_rd_bank",  64'(bus.rd_bank_o),  64'd0);
    step();
    check("rstf_valid3", 64'(bus.rd_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
